// File: rtl/psram_arbiter.sv
// psram_arbiter: round-robin share of two async PSRAM chips among cam0, cam1, mss.
// Define PSRAM_ARB_STATS_EN to add grant counters and a max-wait statistic.
module psram_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int ACC_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam0_req,
  input  logic [ADDR_W-1:0] cam0_addr,
  input  logic [15:0]       cam0_wdata,
  output logic              cam0_ack,
  input  logic              cam1_req,
  input  logic [ADDR_W-1:0] cam1_addr,
  input  logic [15:0]       cam1_wdata,
  output logic              cam1_ack,
  input  logic              mss_req,
  input  logic              mss_we,
  input  logic [1:0]        mss_be,
  input  logic [ADDR_W-1:0] mss_addr,
  input  logic [15:0]       mss_wdata,
  output logic [15:0]       mss_rdata,
  output logic              mss_ack,
  output logic [ADDR_W-2:0] psram_address,
  output logic              psram_ncs0,
  output logic              psram_ncs1,
  output logic              psram_noe0,
  output logic              psram_noe1,
  output logic              psram_nwe,
  output logic [1:0]        psram_nbyte_en,
  output logic [15:0]       psram_dout,
  output logic              psram_dout_oe,
  input  logic [15:0]       psram_din
`ifdef PSRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_cam0,
  output logic [15:0]       stat_cam1,
  output logic [15:0]       stat_mss,
  output logic [15:0]       stat_wait_max
`endif
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, HOLD, RECOVER
  } state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [1:0]        gnt;
  logic [1:0]        pick;
  logic [1:0]        o1;
  logic [1:0]        o2;
  logic              any;
  logic [2:0]        req;
  logic [3:0]        cnt;
  logic              l_we;
  logic              l_chip;
  logic [ADDR_W-1:0] s_addr;
  logic [15:0]       s_wdata;
  logic              s_we;
  logic [1:0]        s_be;

  assign req = {mss_req, cam1_req, cam0_req};

  // first requester at or after ptr, in cam0 -> cam1 -> mss order
  always_comb begin
    o1   = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    o2   = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    any  = |req;
    pick = o2;
    if (req[ptr])
      pick = ptr;
    else if (req[o1])
      pick = o1;
  end

  always_comb begin
    s_addr  = cam0_addr;
    s_wdata = cam0_wdata;
    s_we    = 1'b1;
    s_be    = 2'b11;
    case (pick)
      2'd1: begin
        s_addr  = cam1_addr;
        s_wdata = cam1_wdata;
      end
      2'd2: begin
        s_addr  = mss_addr;
        s_wdata = mss_wdata;
        s_we    = mss_we;
        s_be    = mss_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= 2'd0;
      gnt            <= 2'd0;
      cnt            <= 4'd0;
      l_we           <= 1'b0;
      l_chip         <= 1'b0;
      cam0_ack       <= 1'b0;
      cam1_ack       <= 1'b0;
      mss_ack        <= 1'b0;
      mss_rdata      <= 16'd0;
      psram_address  <= '0;
      psram_ncs0     <= 1'b1;
      psram_ncs1     <= 1'b1;
      psram_noe0     <= 1'b1;
      psram_noe1     <= 1'b1;
      psram_nwe      <= 1'b1;
      psram_nbyte_en <= 2'b11;
      psram_dout     <= 16'd0;
      psram_dout_oe  <= 1'b0;
    end else begin
      cam0_ack <= 1'b0;
      cam1_ack <= 1'b0;
      mss_ack  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt            <= pick;
            ptr            <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            l_we           <= s_we;
            l_chip         <= s_addr[ADDR_W-1];
            psram_address  <= s_addr[ADDR_W-2:0];
            psram_nbyte_en <= ~s_be;
            psram_ncs0     <= s_addr[ADDR_W-1];
            psram_ncs1     <= ~s_addr[ADDR_W-1];
            psram_dout     <= s_wdata;
            psram_dout_oe  <= s_we;
            state          <= SETUP;
          end
        end
        SETUP: begin
          cnt        <= 4'(ACC_CYC - 1);
          psram_nwe  <= ~l_we;
          psram_noe0 <= l_we | l_chip;
          psram_noe1 <= l_we | ~l_chip;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            psram_nwe  <= 1'b1;
            psram_noe0 <= 1'b1;
            psram_noe1 <= 1'b1;
            if (!l_we)
              mss_rdata <= psram_din;
            cam0_ack <= (gnt == 2'd0);
            cam1_ack <= (gnt == 2'd1);
            mss_ack  <= (gnt == 2'd2);
            state    <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          psram_ncs0     <= 1'b1;
          psram_ncs1     <= 1'b1;
          psram_dout_oe  <= 1'b0;
          psram_nbyte_en <= 2'b11;
          cnt            <= 4'(TURN_CYC - 1);
          state          <= (TURN_CYC == 0) ? IDLE : RECOVER;
        end
        RECOVER: begin
          if (cnt == 4'd0)
            state <= IDLE;
          else
            cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PSRAM_ARB_STATS_EN
  logic        grant;
  logic        busy;
  logic [15:0] wcnt [3];
  logic [15:0] wsel;

  assign grant = (state == IDLE) && any;
  assign busy  = (state == SETUP) || (state == ACCESS) || (state == HOLD);

  always_comb begin
    case (pick)
      2'd1:    wsel = wcnt[1];
      2'd2:    wsel = wcnt[2];
      default: wsel = wcnt[0];
    endcase
  end

  // a requester waits while its req is high and it is not being served
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++)
        wcnt[i] <= 16'd0;
      stat_cam0     <= 16'd0;
      stat_cam1     <= 16'd0;
      stat_mss      <= 16'd0;
      stat_wait_max <= 16'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] || (grant && pick == 2'(i)))
          wcnt[i] <= 16'd0;
        else if (!(busy && gnt == 2'(i)) && wcnt[i] != 16'hFFFF)
          wcnt[i] <= wcnt[i] + 16'd1;
      end
      if (stat_clr) begin
        stat_cam0     <= 16'd0;
        stat_cam1     <= 16'd0;
        stat_mss      <= 16'd0;
        stat_wait_max <= 16'd0;
      end else if (grant) begin
        if (pick == 2'd0 && stat_cam0 != 16'hFFFF)
          stat_cam0 <= stat_cam0 + 16'd1;
        if (pick == 2'd1 && stat_cam1 != 16'hFFFF)
          stat_cam1 <= stat_cam1 + 16'd1;
        if (pick == 2'd2 && stat_mss != 16'hFFFF)
          stat_mss <= stat_mss + 16'd1;
        if (wsel > stat_wait_max)
          stat_wait_max <= wsel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: randomized requesters checked cycle by cycle against a
// transaction-timeline reference model of the arbiter.
module tb_psram_arbiter;
  localparam int AW   = 23;
  localparam int ACC  = 4;
  localparam int TURN = 2;
  localparam int OCC  = ACC + 3 + TURN;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          we;
    logic [1:0]    be;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req = 3'b000;
  logic [AW-1:0] addr [3];
  logic [15:0]   wdata [3];
  logic          mss_we = 1'b0;
  logic [1:0]    mss_be = 2'b00;
  logic [15:0]   din = 16'd0;
  logic          cam0_ack, cam1_ack, mss_ack;
  logic [15:0]   mss_rdata;
  logic [AW-2:0] psram_address;
  logic          ncs0, ncs1, noe0, noe1, nwe, oe;
  logic [1:0]    nbe;
  logic [15:0]   dout;
`ifdef PSRAM_ARB_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_cam0, stat_cam1, stat_mss, stat_wait_max;
`endif

  psram_arbiter #(.ADDR_W(AW), .ACC_CYC(ACC), .TURN_CYC(TURN)) dut (
    .clk(clk), .reset(reset),
    .cam0_req(req[0]), .cam0_addr(addr[0]),
    .cam0_wdata(wdata[0]), .cam0_ack(cam0_ack),
    .cam1_req(req[1]), .cam1_addr(addr[1]),
    .cam1_wdata(wdata[1]), .cam1_ack(cam1_ack),
    .mss_req(req[2]), .mss_we(mss_we), .mss_be(mss_be),
    .mss_addr(addr[2]), .mss_wdata(wdata[2]),
    .mss_rdata(mss_rdata), .mss_ack(mss_ack),
    .psram_address(psram_address),
    .psram_ncs0(ncs0), .psram_ncs1(ncs1),
    .psram_noe0(noe0), .psram_noe1(noe1),
    .psram_nwe(nwe), .psram_nbyte_en(nbe),
    .psram_dout(dout), .psram_dout_oe(oe),
    .psram_din(din)
`ifdef PSRAM_ARB_STATS_EN
    ,
    .stat_clr(stat_clr), .stat_cam0(stat_cam0),
    .stat_cam1(stat_cam1), .stat_mss(stat_mss),
    .stat_wait_max(stat_wait_max)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // requester queues and reference-model state
  txn_t       q [3][$];
  bit         active [3];
  int         wstart [3];
  int         ack_cyc [3];
  int         dack [3];
  int         dack_cyc [3];
  int         aord [$];
  int         cyc = 0;
  bit         m_busy = 0;
  int         m_g = 0;
  int         m_c = 0;
  int         m_free = 0;
  int         m_ptr = 0;
  txn_t       m_t;
  logic [15:0] m_rd = 16'd0;
  int         st_g [3];
  int         st_w = 0;
  bit         rst_prev = 1;
  bit         rst_hold = 1;
  bit         rst_arm = 0;
  bit         gap_en = 0;
  bit         din_fix = 0;
  bit         clr_now = 0;
  bit         clr_arm = 0;
  int         lo_ncs0 = 0;
  int         lo_nwe = 0;

  function automatic txn_t mk(logic [AW-1:0] a, logic [15:0] d,
                              logic w, logic [1:0] b);
    txn_t t;
    t.addr  = a;
    t.wdata = d;
    t.we    = w;
    t.be    = b;
    return t;
  endfunction

  function automatic txn_t rnd_txn(int i);
    if (i < 2)
      return mk(AW'($urandom), 16'($urandom), 1'b1, 2'b11);
    return mk(AW'($urandom), 16'($urandom), 1'($urandom), 2'($urandom));
  endfunction

  task automatic step();
    logic [5:0] es;
    logic [2:0] ea;
    logic [2:0] da;
    logic       chip;
    int         off;
    bit         inacc;
    int         pk;
    bit         clr;
    @(negedge clk);
    cyc++;
    // expected pin state for this cycle from the transaction timeline
    es    = 6'b111110;
    ea    = 3'b000;
    off   = -1;
    inacc = 0;
    if (m_busy && !rst_prev) begin
      off   = cyc - m_c - 1;
      inacc = (off >= 0) && (off <= ACC + 1);
    end
    if (inacc) begin
      chip  = m_t.addr[AW-1];
      es[5] = chip;
      es[4] = ~chip;
      es[0] = m_t.we;
      if (off >= 1 && off <= ACC) begin
        if (m_t.we)
          es[1] = 1'b0;
        else if (chip)
          es[2] = 1'b0;
        else
          es[3] = 1'b0;
      end
      if (off == ACC + 1)
        ea[m_g] = 1'b1;
      chk("addr", 32'(psram_address), 32'(m_t.addr[AW-2:0]));
      chk("nbyte_en", 32'(nbe), 32'(2'(~m_t.be)));
      if (m_t.we)
        chk("dout", 32'(dout), 32'(m_t.wdata));
      if (off == ACC + 1 && !m_t.we)
        chk("rdata", 32'(mss_rdata), 32'(m_rd));
    end
    chk("strobes", 32'({ncs0, ncs1, noe0, noe1, nwe, oe}), 32'(es));
    da = {mss_ack, cam1_ack, cam0_ack};
    chk("acks", 32'(da), 32'(ea));
    if (rst_prev) begin
      chk("rst_addr", 32'(psram_address), 32'd0);
      chk("rst_nbe", 32'(nbe), 32'd3);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_rdata", 32'(mss_rdata), 32'd0);
    end
`ifdef PSRAM_ARB_STATS_EN
    chk("stat_cam0", 32'(stat_cam0), st_g[0]);
    chk("stat_cam1", 32'(stat_cam1), st_g[1]);
    chk("stat_mss", 32'(stat_mss), st_g[2]);
    chk("stat_wmax", 32'(stat_wait_max), st_w);
`endif
    if (!ncs0) lo_ncs0++;
    if (!nwe)  lo_nwe++;
    for (int i = 0; i < 3; i++) begin
      if (da[i]) begin
        dack[i]++;
        dack_cyc[i] = cyc;
        aord.push_back(i);
      end
    end
    // model completion
    if (inacc && off == ACC + 1) begin
      void'(q[m_g].pop_front());
      active[m_g] = 0;
      ack_cyc[m_g] = cyc;
    end
    // drive stimulus for the coming edge
    din   = din_fix ? 16'h5A5A : 16'($urandom);
    reset = rst_hold || (rst_arm && inacc && m_g == 1 && off == 2);
    if (reset && rst_arm) begin
      rst_arm = 0;
      q[0].push_back(mk(23'h000200, 16'h1234, 1'b1, 2'b11));
    end
    for (int i = 0; i < 3; i++) begin
      if (!active[i] && q[i].size() > 0 &&
          (!gap_en || $urandom_range(0, 2) == 0)) begin
        active[i] = 1;
        wstart[i] = (ack_cyc[i] == cyc) ? cyc + 1 : cyc;
      end
      req[i] = active[i];
      if (active[i]) begin
        addr[i]  = q[i][0].addr;
        wdata[i] = q[i][0].wdata;
        if (i == 2) begin
          mss_we = q[i][0].we;
          mss_be = q[i][0].be;
        end
      end
    end
    if (inacc && off == ACC && !m_t.we)
      m_rd = din;
    // model arbitration at the coming edge
    clr = 0;
    if (reset) begin
      m_busy = 0;
      m_ptr  = 0;
      m_free = cyc + 1;
      st_w   = 0;
      for (int i = 0; i < 3; i++) begin
        st_g[i] = 0;
        if (active[i])
          wstart[i] = cyc + 1;
      end
    end else begin
      if (m_busy && cyc >= m_free)
        m_busy = 0;
      pk = -1;
      if (!m_busy && cyc >= m_free) begin
        for (int k = 0; k < 3; k++) begin
          int j;
          j = (m_ptr + k) % 3;
          if (pk < 0 && active[j])
            pk = j;
        end
      end
      if (pk >= 0) begin
        m_busy = 1;
        m_g    = pk;
        m_c    = cyc;
        m_t    = q[pk][0];
        m_free = cyc + OCC;
        m_ptr  = (pk + 1) % 3;
      end
      clr = clr_now || (clr_arm && pk == 0);
      if (clr) begin
        clr_arm = 0;
        st_w    = 0;
        for (int i = 0; i < 3; i++)
          st_g[i] = 0;
      end else if (pk >= 0) begin
        if (st_g[pk] < 65535)
          st_g[pk]++;
        if (cyc - wstart[pk] > st_w)
          st_w = cyc - wstart[pk];
      end
    end
`ifdef PSRAM_ARB_STATS_EN
    stat_clr = clr;
`endif
    rst_prev = reset;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size() > 0 || m_busy) &&
           n < budget) begin
      step();
      n++;
    end
    if (n >= budget)
      chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int s0, s1, s2, i;
    for (int k = 0; k < 3; k++) begin
      addr[k]     = '0;
      wdata[k]    = '0;
      active[k]   = 0;
      ack_cyc[k]  = -10;
      dack[k]     = 0;
      dack_cyc[k] = 0;
      st_g[k]     = 0;
      wstart[k]   = 0;
    end
    repeat (3) step();
    rst_hold = 0;

    // single cam0 write
    lo_ncs0 = 0;
    lo_nwe  = 0;
    q[0].push_back(mk(23'h000123, 16'hBEEF, 1'b1, 2'b11));
    drain(100);
    chk("ncs0_low_clks", lo_ncs0, 6);
    chk("nwe_low_clks", lo_nwe, 4);
    chk("cam0_latency", dack_cyc[0] - wstart[0], ACC + 2);

    // mss read from chip 1
    din_fix = 1;
    q[2].push_back(mk(23'h400010, 16'h0000, 1'b0, 2'b11));
    drain(100);
    din_fix = 0;
    chk("rd_5a5a", 32'(mss_rdata), 32'h5A5A);

    // all three saturated for 9 accesses
    s0 = dack[0]; s1 = dack[1]; s2 = dack[2];
    aord.delete();
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        q[j].push_back(rnd_txn(j));
    drain(400);
    chk("sat_cam0_acks", dack[0] - s0, 3);
    chk("sat_cam1_acks", dack[1] - s1, 3);
    chk("sat_mss_acks", dack[2] - s2, 3);
    for (int k = 0; k < 9 && k < aord.size(); k++)
      chk("sat_order", aord[k], k % 3);
    chk("sat_count", aord.size(), 9);

    // mss byte write, upper byte only
    q[2].push_back(mk(AW'($urandom), 16'($urandom), 1'b1, 2'b10));
    drain(100);

    // randomized mix with idle gaps
    gap_en = 1;
    for (int k = 0; k < 45; k++) begin
      i = $urandom_range(0, 2);
      q[i].push_back(rnd_txn(i));
    end
    drain(5000);
    gap_en = 0;

    // reset in the 2nd ACCESS clock of a cam1 write
    s1 = dack[1];
    aord.delete();
    rst_arm = 1;
    q[1].push_back(mk(23'h000777, 16'hC0DE, 1'b1, 2'b11));
    drain(200);
    chk("rst_cam1_acks", dack[1] - s1, 1);
    chk("rst_first_cam0", aord.size() > 0 ? aord[0] : -1, 0);

`ifdef PSRAM_ARB_STATS_EN
    clr_now = 1;
    step();
    clr_now = 0;
    for (int k = 0; k < 5; k++)
      q[0].push_back(rnd_txn(0));
    drain(200);
    chk("stat5", 32'(stat_cam0), 32'd5);
    clr_arm = 1;
    q[0].push_back(rnd_txn(0));
    drain(100);
    chk("stat_clr", 32'(stat_cam0), 32'd0);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
